// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller and the direct-mapped cache.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    // Refill controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_RD = 3'd1,
        FILL   = 3'd2,
        RESP   = 3'd3,
        MEM_WR = 3'd4
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register; increments are dropped once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill/write-through controller sitting between the CPU, a direct-mapped
// cache and main memory. Hits are answered in the request cycle; misses run a
// memory read, fill the cache and replay the data; stores write memory and
// update the cache in the ack cycle.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // CPU side
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    // Cache lookup and write port
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    // Main memory channel
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    // Performance counters
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_e                state;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  hit_inc;
    logic                  miss_inc;

    // State, latched address and latched/captured data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    // Next state and outputs; everything is held quiet while reset is asserted
    // so a pending request cannot raise stall or bump a counter during reset.
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        stall       = 1'b0;
        cpu_rdata   = '0;
        cache_we    = 1'b0;
        cache_addr  = addr_q;
        cache_wdata = data_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = data_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;

        if (rst_n) begin
            case (state)
                IDLE: begin
                    // Store wins over a simultaneous load
                    if (cpu_we) begin
                        stall     = 1'b1;
                        addr_nxt  = cpu_addr;
                        data_nxt  = cpu_wdata;
                        state_nxt = MEM_WR;
                    end else if (cpu_re) begin
                        if (cache_hit) begin
                            cpu_rdata = cache_rdata;
                            hit_inc   = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            addr_nxt  = cpu_addr;
                            miss_inc  = 1'b1;
                            state_nxt = MEM_RD;
                        end
                    end
                end

                MEM_RD: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        data_nxt  = mem_rdata;
                        state_nxt = FILL;
                    end
                end

                FILL: begin
                    stall     = 1'b1;
                    cache_we  = 1'b1;
                    state_nxt = RESP;
                end

                RESP: begin
                    cpu_rdata = data_q;
                    state_nxt = IDLE;
                end

                MEM_WR: begin
                    stall   = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ack) begin
                        cache_we  = 1'b1;
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule
